id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection and write-back bypass for the five-stage RISC-V pipeline. It captures the decoded instruction from ID and presents it to EX, including the `ex_rs1`/`ex_rs2`/`ex_rd` fields consumed by the forwarding unit. It inserts a bubble and freezes PC and IF/ID when a load is followed by a dependent instruction. It also squashes the captured instruction on a taken branch/jump flush.

## Interface
Parameters:
- XLEN, 32, datapath width
- CNT_W, 16, width of the load-use stall counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- hold  in  1  global freeze (memory busy); all state held
- flush_ex  in  1  taken branch/jump resolved in EX; squash the ID instruction
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  PC of the ID instruction
- id_rs1, id_rs2, id_rd  in  5 each  register fields
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  decoded immediate
- id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_branch, id_jump  in  1 each  control bits
- id_aluop  in  4  ALU operation
- wb_regwrite  in  1  WB stage writes the register file this cycle
- wb_rd  in  5  WB destination
- wb_data  in  XLEN  WB write data
- ex_valid  out  1  EX holds a real instruction
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered copies
- ex_rs1, ex_rs2, ex_rd  out  5 each  registered fields, to the forwarding unit
- ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_branch, ex_jump  out  1 each
- ex_aluop  out  4
- pc_write  out  1  PC may advance
- if_id_write  out  1  IF/ID register may load
- load_use_stall  out  1  hazard bubble being inserted this cycle
- stall_count  out  CNT_W  saturating count of load-use stall cycles

## Operation
- Hazard condition (combinational, from registered EX state and current ID inputs): `ex_valid & ex_memread & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2)`.
- load_use_stall = hazard & !flush_ex & !hold.
- pc_write = if_id_write = !hold & !load_use_stall.
- Register update priority per clock edge:
  1. Reset.
  2. hold: all registers keep their values.
  3. flush_ex: capture a bubble.
  4. load_use_stall: capture a bubble.
  5. Otherwise: capture ID; ex_valid <= id_valid.
- Bubble contents:
  - ex_valid = 0.
  - All control bits 0; ex_aluop = 0.
  - ex_rd = ex_rs1 = ex_rs2 = 0, so the forwarding unit never matches a bubble.
  - Data fields 0.
- Captured with id_valid=0: control bits and rd forced to 0, same as a bubble.
- WB bypass on capture: if wb_regwrite & wb_rd!=0 & wb_rd==id_rs1, then ex_rs1_data <= wb_data, else id_rs1_data. Same rule for rs2, applied independently.
- stall_count:
  - +1 on each cycle load_use_stall=1.
  - Saturates at all-ones.
  - Unaffected by hold and flush.

## Timing
- Reset (rst_n=0 at clk edge): every registered output is 0, including ex_valid=0 and stall_count=0. Combinational outputs then give pc_write=if_id_write=1 and load_use_stall=0 while hold=0.
- Capture latency: 1 cycle, ID inputs to ex_* outputs.
- A load-use hazard produces exactly one bubble. The next edge moves the load to MEM, so the hazard clears and the dependent instruction is captured one cycle late.
- flush_ex with a hazard in the same cycle: flush wins. load_use_stall=0, PC advances, bubble captured.
- hold with flush_ex: hold wins and nothing changes. The flush source keeps flush_ex asserted until hold drops.
- hold with a hazard: load_use_stall=0 and stall_count is not incremented. The hazard re-evaluates after hold drops.
- rs1==rs2==ex_rd: a single stall. rd=0 load: never stalls.
- Reset mid-stall: the next cycle is the reset state; the bubble and stall are discarded.

## Test plan
- Reset: drive rst_n=0 for 2 cycles with random inputs -> all ex_* = 0, stall_count=0, pc_write=1.
- Pass-through: `addi x5` with id_imm=0x10, id_rs1_data=0xA -> next cycle ex_rd=5, ex_imm=0x10, ex_rs1_data=0xA, ex_regwrite=1, ex_valid=1.
- Load-use: `lw x6` captured, then ID presents rs2=6 -> one cycle of load_use_stall=1, pc_write=0, bubble with ex_rd=0. Next cycle the dependent instruction is captured; stall_count=1.
- Flush with hazard: same setup as load-use plus flush_ex=1 -> load_use_stall=0, pc_write=1, ex_valid=0 next cycle, stall_count unchanged.
- WB bypass: id_rs1=7, id_rs1_data=0x1, wb_regwrite=1, wb_rd=7, wb_data=0xDEAD -> ex_rs1_data=0xDEAD. Repeat with wb_rd=0 -> ex_rs1_data=0x1.
- Hold and saturation: hold=1 for 3 cycles -> outputs frozen, pc_write=0. Force stall_count to 0xFFFF with a further hazard -> stays at 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection
// and write-back bypass of the register-file read data.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold,
  input  logic            flush_ex,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            id_memwrite,
  input  logic            id_memtoreg,
  input  logic            id_alusrc,
  input  logic            id_branch,
  input  logic            id_jump,
  input  logic [3:0]      id_aluop,
  input  logic            wb_regwrite,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic            ex_memtoreg,
  output logic            ex_alusrc,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic [3:0]      ex_aluop,
  output logic            pc_write,
  output logic            if_id_write,
  output logic            load_use_stall,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            memtoreg;
    logic            alusrc;
    logic            branch;
    logic            jump;
    logic [3:0]      aluop;
  } id_ex_t;

  id_ex_t q;
  id_ex_t cap;
  logic   hazard;
  logic   byp1;
  logic   byp2;

  assign byp1 = wb_regwrite & (wb_rd != 5'd0)
              & (wb_rd == id_rs1);
  assign byp2 = wb_regwrite & (wb_rd != 5'd0)
              & (wb_rd == id_rs2);

  assign hazard = q.valid & q.memread
                & (q.rd != 5'd0) & id_valid
                & ((q.rd == id_rs1) | (q.rd == id_rs2));

  assign load_use_stall = hazard & ~flush_ex & ~hold;
  assign pc_write       = ~hold & ~load_use_stall;
  assign if_id_write    = ~hold & ~load_use_stall;

  // Build the ID bundle to capture; invalid slots carry no rd/controls.
  always_comb begin
    cap          = '0;
    cap.valid    = id_valid;
    cap.pc       = id_pc;
    cap.rs1      = id_rs1;
    cap.rs2      = id_rs2;
    cap.rs1_data = byp1 ? wb_data : id_rs1_data;
    cap.rs2_data = byp2 ? wb_data : id_rs2_data;
    cap.imm      = id_imm;
    if (id_valid) begin
      cap.rd       = id_rd;
      cap.regwrite = id_regwrite;
      cap.memread  = id_memread;
      cap.memwrite = id_memwrite;
      cap.memtoreg = id_memtoreg;
      cap.alusrc   = id_alusrc;
      cap.branch   = id_branch;
      cap.jump     = id_jump;
      cap.aluop    = id_aluop;
    end
  end

  // Pipeline register: hold > flush/stall bubble > capture.
  always_ff @(posedge clk) begin
    if (!rst_n)
      q <= '0;
    else if (hold)
      q <= q;
    else if (flush_ex | load_use_stall)
      q <= '0;
    else
      q <= cap;
  end

  // Saturating count of inserted load-use bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_count <= '0;
    else if (load_use_stall && stall_count != '1)
      stall_count <= stall_count + 1'b1;
  end

  assign ex_valid    = q.valid;
  assign ex_pc       = q.pc;
  assign ex_rs1      = q.rs1;
  assign ex_rs2      = q.rs2;
  assign ex_rd       = q.rd;
  assign ex_rs1_data = q.rs1_data;
  assign ex_rs2_data = q.rs2_data;
  assign ex_imm      = q.imm;
  assign ex_regwrite = q.regwrite;
  assign ex_memread  = q.memread;
  assign ex_memwrite = q.memwrite;
  assign ex_memtoreg = q.memtoreg;
  assign ex_alusrc   = q.alusrc;
  assign ex_branch   = q.branch;
  assign ex_jump     = q.jump;
  assign ex_aluop    = q.aluop;

endmodule
